neuron_layer_ctrl: RTL and testbench

- Sequences one shared Q1.6 multiply-accumulate datapath to evaluate a full dense layer: out[j] = sum_i w[j][i]*x[i] + b[j].
- Fetches weights, inputs and biases from external synchronous-read memories and accumulates at full precision.
- Writes one 8-bit Q1.6 result per output neuron to an output buffer.
- Sits between the layer memories and the next layer, started by the network top-level sequencer.

---
 rtl/neuron_layer_ctrl_if.sv | 39 +++
 rtl/neuron_layer_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_neuron_layer_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_layer_ctrl_if.sv
// Bus bundle between the dense-layer controller, its weight/input/bias memories,
// the output buffer and the network sequencer.
interface neuron_layer_ctrl_if #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_OUT = 4
);
    localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned WW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;

    logic          start;
    logic          busy;
    logic          done;
    logic          ovr;
    logic          rd_en;
    logic [WW-1:0] w_addr;
    logic [7:0]    w_data;
    logic [IW-1:0] x_addr;
    logic [7:0]    x_data;
    logic [OW-1:0] b_addr;
    logic [7:0]    b_data;
    logic          out_we;
    logic [OW-1:0] out_addr;
    logic [7:0]    out_data;

    // Controller side: drives addresses, strobes and results.
    modport master (
        input  start, w_data, x_data, b_data,
        output busy, done, ovr, rd_en, w_addr, x_addr, b_addr,
               out_we, out_addr, out_data
    );

    // Memory / sequencer side.
    modport slave (
        output start, w_data, x_data, b_data,
        input  busy, done, ovr, rd_en, w_addr, x_addr, b_addr,
               out_we, out_addr, out_data
    );
endinterface

// File: rtl/neuron_layer_ctrl.sv
// Dense-layer sequencer around one shared Q1.6 MAC: out[j] = sum_i w[j][i]*x[i] + b[j].
// Define NEURON_SAT_EN to saturate results to the Q1.6 range instead of sign+truncate.
module neuron_layer_ctrl #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_OUT = 4,
    parameter int unsigned ACC_W = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    neuron_layer_ctrl_if.master   bus
);
    localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned WW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
    localparam logic [OW-1:0] J_LAST = OW'(N_OUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_B = 3'd1;
    localparam logic [2:0] S_INIT   = 3'd2;
    localparam logic [2:0] S_RD     = 3'd3;
    localparam logic [2:0] S_MAC    = 3'd4;
    localparam logic [2:0] S_WR     = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [IW-1:0]    i_q, i_d;
    logic [OW-1:0]    j_q, j_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic             rd_en_q, rd_en_d;
    logic [WW-1:0]    w_addr_q, w_addr_d;
    logic [IW-1:0]    x_addr_q, x_addr_d;
    logic [OW-1:0]    b_addr_q, b_addr_d;
    logic             out_we_q, out_we_d;
    logic [OW-1:0]    out_addr_q, out_addr_d;
    logic [7:0]       out_data_q, out_data_d;

    logic signed [15:0]      prod_c;
    logic signed [ACC_W-1:0] bias_c;

    // Full-precision Q2.12 product and bias aligned to the Q.12 accumulator.
    assign prod_c = $signed(bus.w_data) * $signed(bus.x_data);
    assign bias_c = ACC_W'($signed(bus.b_data)) <<< 6;

    // acc >>> 6 fits in 8 signed bits only when acc[ACC_W-1:13] is all sign.
    function automatic logic range_ovf(input logic [ACC_W-1:0] a);
        logic [ACC_W-14:0] hi;
        hi = a[ACC_W-1:13];
        return !((&hi) || !(|hi));
    endfunction

    function automatic logic [7:0] fmt(input logic [ACC_W-1:0] a);
`ifdef NEURON_SAT_EN
        if (range_ovf(a)) begin
            return a[ACC_W-1] ? 8'h80 : 8'h7F;
        end
        return a[13:6];
`else
        return {a[ACC_W-1], a[12:6]};
`endif
    endfunction

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        acc_d      = acc_q;
        ovr_d      = ovr_q;
        w_addr_d   = w_addr_q;
        x_addr_d   = x_addr_q;
        b_addr_d   = b_addr_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    j_d     = '0;
                    ovr_d   = 1'b0;
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: state_d = S_INIT;
            S_INIT: begin
                acc_d   = bias_c;
                i_d     = '0;
                state_d = S_RD;
            end
            S_RD: state_d = S_MAC;
            S_MAC: begin
                acc_d = acc_q + ACC_W'(prod_c);
                if (i_q == I_LAST) begin
                    state_d = S_WR;
                end else begin
                    i_d     = i_q + IW'(1);
                    state_d = S_RD;
                end
            end
            S_WR: begin
                if (j_q == J_LAST) begin
                    state_d = S_DONE;
                end else begin
                    j_d     = j_q + OW'(1);
                    state_d = S_LOAD_B;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        rd_en_d  = (state_d == S_LOAD_B) || (state_d == S_RD);
        out_we_d = (state_d == S_WR);

        if (state_d == S_LOAD_B) begin
            b_addr_d = j_d;
        end
        if (state_d == S_RD) begin
            w_addr_d = WW'(32'(j_d) * N_IN + 32'(i_d));
            x_addr_d = i_d;
        end
        if (state_d == S_WR) begin
            out_addr_d = j_d;
            out_data_d = fmt(acc_d);
            ovr_d      = ovr_q | range_ovf(acc_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            rd_en_q    <= 1'b0;
            w_addr_q   <= '0;
            x_addr_q   <= '0;
            b_addr_q   <= '0;
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            acc_q      <= acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            rd_en_q    <= rd_en_d;
            w_addr_q   <= w_addr_d;
            x_addr_q   <= x_addr_d;
            b_addr_q   <= b_addr_d;
            out_we_q   <= out_we_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ovr      = ovr_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.w_addr   = w_addr_q;
    assign bus.x_addr   = x_addr_q;
    assign bus.b_addr   = b_addr_q;
    assign bus.out_we   = out_we_q;
    assign bus.out_addr = out_addr_q;
    assign bus.out_data = out_data_q;

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Bench for neuron_layer_ctrl: memory models, an arithmetic layer model with a
// cycle-position timeline, directed test-plan cases, a mid-layer reset and random layers.
module tb_neuron_layer_ctrl;
    localparam int unsigned N_IN  = 4;
    localparam int unsigned N_OUT = 4;
    localparam int unsigned ACC_W = 20;
    localparam int NB       = 2 * N_IN + 3;
    localparam int LAT      = N_OUT * NB + 1;
    localparam int ACC_HALF = 1 << (ACC_W - 1);
    localparam int ACC_MOD  = 1 << ACC_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    neuron_layer_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT)) ifc ();
    neuron_layer_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    logic [7:0] w_mem [N_IN*N_OUT];
    logic [7:0] x_mem [N_IN];
    logic [7:0] b_mem [N_OUT];

    // Synchronous-read memories, one cycle latency.
    always @(posedge clk) begin
        if (ifc.rd_en) begin
            ifc.w_data <= w_mem[ifc.w_addr];
            ifc.x_data <= x_mem[ifc.x_addr];
            ifc.b_data <= b_mem[ifc.b_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Layer model: plain integer arithmetic of the dense layer.
    logic [7:0] exp_out [N_OUT];
    bit         exp_ov  [N_OUT];

    function automatic void compute_expect();
        for (int j = 0; j < int'(N_OUT); j++) begin
            int acc, r;
            logic [7:0] rb;
            acc = int'($signed(b_mem[j])) * 64;
            for (int i = 0; i < int'(N_IN); i++)
                acc += int'($signed(w_mem[j*N_IN+i])) * int'($signed(x_mem[i]));
            while (acc >= ACC_HALF) acc -= ACC_MOD;
            while (acc < -ACC_HALF) acc += ACC_MOD;
            r  = acc >>> 6;
            rb = 8'(r);
            exp_ov[j] = (r < -128) || (r > 127);
`ifdef NEURON_SAT_EN
            exp_out[j] = exp_ov[j] ? ((r < 0) ? 8'h80 : 8'h7F) : rb;
`else
            exp_out[j] = {(acc < 0) ? 1'b1 : 1'b0, rb[6:0]};
`endif
        end
    endfunction

    // Position within the current layer: 0 idle, 1..LAT after the start-accept edge.
    int m_cnt = 0;
    bit m_ovr = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0;
            m_ovr = 1'b0;
        end else if (m_cnt == 0) begin
            if (ifc.start) begin
                compute_expect();
                m_cnt = 1;
                m_ovr = 1'b0;
            end
        end else begin
            m_cnt = (m_cnt == LAT) ? 0 : m_cnt + 1;
            if (m_cnt != 0 && m_cnt < LAT && ((m_cnt - 1) % NB) == NB - 1)
                m_ovr = m_ovr | exp_ov[(m_cnt - 1) / NB];
        end
    end

    // Per-cycle comparison of every output against the timeline model.
    always @(negedge clk) begin
        int c, jj, p, ii;
        bit e_rd, e_we;
        c = m_cnt; jj = 0; p = 0; e_rd = 1'b0; e_we = 1'b0;
        if (c != 0 && c < LAT) begin
            jj   = (c - 1) / NB;
            p    = (c - 1) % NB;
            e_we = (p == NB - 1);
            e_rd = (p == 0) || (p >= 2 && p < NB - 1 && (p % 2) == 0);
        end
        chk("busy",   ifc.busy,   c != 0);
        chk("done",   ifc.done,   c == LAT);
        chk("rd_en",  ifc.rd_en,  e_rd);
        chk("out_we", ifc.out_we, e_we);
        chk("ovr",    ifc.ovr,    m_ovr);
        if (e_rd && p == 0) chk("b_addr", ifc.b_addr, jj);
        if (e_rd && p != 0) begin
            ii = (p - 2) / 2;
            chk("w_addr", ifc.w_addr, jj * N_IN + ii);
            chk("x_addr", ifc.x_addr, ii);
        end
        if (e_we) begin
            chk("out_addr", ifc.out_addr, jj);
            chk("out_data", ifc.out_data, exp_out[jj]);
        end
    end

    // Write / done / busy monitor.
    int         cyc_cnt = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         busy_cnt = 0;
    int         wa_q[$];
    logic [7:0] wd_q[$];
    always @(posedge clk) cyc_cnt++;
    always @(negedge clk) begin
        if (ifc.out_we) begin
            wa_q.push_back(int'(ifc.out_addr));
            wd_q.push_back(ifc.out_data);
        end
        if (ifc.done) begin
            done_cnt++;
            done_cyc = cyc_cnt;
        end
        if (ifc.busy) busy_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mems(input logic [7:0] w, input logic [7:0] x, input logic [7:0] b);
        for (int k = 0; k < int'(N_IN*N_OUT); k++) w_mem[k] = w;
        for (int k = 0; k < int'(N_IN); k++) x_mem[k] = x;
        for (int k = 0; k < int'(N_OUT); k++) b_mem[k] = b;
    endtask

    // One full layer; noisy re-pulses start at cycles 5, 20 and in DONE.
    task automatic run_layer(input bit noisy);
        int dn0, bz0, acc_cyc;
        wa_q.delete();
        wd_q.delete();
        dn0 = done_cnt;
        bz0 = busy_cnt;
        ifc.start = 1'b1;
        step();
        acc_cyc = cyc_cnt;
        ifc.start = 1'b0;
        for (int c = 1; c <= LAT + 3; c++) begin
            ifc.start = noisy && (c == 5 || c == 20 || c == LAT);
            step();
        end
        ifc.start = 1'b0;
        chk("done_count", done_cnt - dn0, 1);
        chk("write_count", wa_q.size(), N_OUT);
        chk("latency", done_cyc - acc_cyc + 1, LAT);
        chk("busy_cycles", busy_cnt - bz0, LAT);
        for (int k = 0; k < wa_q.size(); k++) chk("write_order", wa_q[k], k);
    endtask

    logic [7:0] exp_sat_n0;

    initial begin
        rst = 1'b1;
        ifc.start = 1'b0;
        set_mems(8'h40, 8'h10, 8'h00);
        #12;
        chk("rst_busy",     ifc.busy,     0);
        chk("rst_done",     ifc.done,     0);
        chk("rst_ovr",      ifc.ovr,      0);
        chk("rst_rd_en",    ifc.rd_en,    0);
        chk("rst_out_we",   ifc.out_we,   0);
        chk("rst_w_addr",   ifc.w_addr,   0);
        chk("rst_out_data", ifc.out_data, 0);
        step();
        rst = 1'b0;
        step();

        // Defaults: 4 * (0x40*0x10) = 4096 -> 64 = 0x40 per neuron.
        run_layer(1'b1);
        for (int k = 0; k < wd_q.size(); k++) chk("dflt_out", wd_q[k], 8'h40);
        chk("dflt_ovr", ifc.ovr, 0);

        // Neuron 0 at full scale: acc = 72644.
        set_mems(8'h40, 8'h7F, 8'h00);
        for (int i = 0; i < int'(N_IN); i++) w_mem[i] = 8'h7F;
        b_mem[0] = 8'h7F;
        run_layer(1'b0);
`ifdef NEURON_SAT_EN
        exp_sat_n0 = 8'h7F;
`else
        exp_sat_n0 = 8'h6F;
`endif
        if (wd_q.size() > 0) chk("n0_big", wd_q[0], exp_sat_n0);
        chk("n0_big_ovr", ifc.ovr, 1);

        // Neuron 1 negative: r = -256.
        set_mems(8'h00, 8'h40, 8'h00);
        for (int i = 0; i < int'(N_IN); i++) w_mem[N_IN + i] = 8'hC0;
        run_layer(1'b0);
        if (wd_q.size() > 1) chk("n1_neg", wd_q[1], 8'h80);
        chk("n1_neg_ovr", ifc.ovr, 1);

        // Single tiny negative product floors to -1 LSB.
        set_mems(8'h00, 8'h00, 8'h00);
        w_mem[0] = 8'hFF;
        x_mem[0] = 8'h01;
        run_layer(1'b1);
        if (wd_q.size() > 0) chk("floor_m1", wd_q[0], 8'hFF);
        if (wd_q.size() > 1) chk("zero_n1", wd_q[1], 8'h00);
        chk("floor_ovr", ifc.ovr, 0);

        // Reset during MAC of neuron 2 aborts immediately.
        set_mems(8'h7F, 8'h7F, 8'h7F);
        wa_q.delete();
        wd_q.delete();
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
        repeat (25) step();
        rst = 1'b1;
        #1;
        chk("abort_busy",     ifc.busy,     0);
        chk("abort_rd_en",    ifc.rd_en,    0);
        chk("abort_ovr",      ifc.ovr,      0);
        chk("abort_b_addr",   ifc.b_addr,   0);
        chk("abort_x_addr",   ifc.x_addr,   0);
        chk("abort_out_addr", ifc.out_addr, 0);
        chk("abort_out_data", ifc.out_data, 0);
        repeat (3) step();
        rst = 1'b0;
        repeat (4) step();
        chk("abort_writes", wa_q.size(), 2);
        set_mems(8'h40, 8'h10, 8'h00);
        run_layer(1'b0);
        for (int k = 0; k < wd_q.size(); k++) chk("post_rst_out", wd_q[k], 8'h40);

        // Randomized layers, alternating full-range and small-magnitude operands.
        for (int t = 0; t < 10; t++) begin
            for (int k = 0; k < int'(N_IN*N_OUT); k++)
                w_mem[k] = (t % 3 == 0) ? 8'($urandom) : 8'($urandom_range(0, 31) - 16);
            for (int k = 0; k < int'(N_IN); k++)
                x_mem[k] = (t % 3 == 0) ? 8'($urandom) : 8'($urandom_range(0, 31) - 16);
            for (int k = 0; k < int'(N_OUT); k++)
                b_mem[k] = 8'($urandom);
            run_layer(t % 2 == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
